// File: rtl/tmr_pkg.sv
// Shared TMR definitions: recovery FSM states, voter flag bit positions, core indices and helpers.
package tmr_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StConfirm,
      StHold,
      StCopy,
      StPcload,
      StRelease,
      StFatal
   } tmr_state_e;

   localparam int unsigned VsBitA = 0;
   localparam int unsigned VsBitB = 1;
   localparam int unsigned VsBitC = 2;

   localparam logic [1:0] CoreA = 2'd0;
   localparam logic [1:0] CoreB = 2'd1;
   localparam logic [1:0] CoreC = 2'd2;

   function automatic logic is_onehot3(input logic [2:0] v);
      return (v != 3'b000) && ((v & (v - 3'b001)) == 3'b000);
   endfunction

   // 1=A, 2=B, 3=C, 0=none
   function automatic logic [1:0] onehot_to_code(input logic [2:0] v);
      logic [1:0] code;
      code = 2'd0;
      if (v[VsBitA])      code = 2'd1;
      else if (v[VsBitB]) code = 2'd2;
      else if (v[VsBitC]) code = 2'd3;
      return code;
   endfunction

endpackage

// File: rtl/tmr_resync_mux.sv
// Donor selection for a given victim, and the donor read-data mux feeding the victim write port.
module tmr_resync_mux
   import tmr_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [2:0]      victim_i,
   input  logic [1:0]      donor_i,
   input  logic [XLEN-1:0] rd_data_a_i,
   input  logic [XLEN-1:0] rd_data_b_i,
   input  logic [XLEN-1:0] rd_data_c_i,
   output logic [1:0]      donor_sel_o,
   output logic [XLEN-1:0] wr_data_o
);

   always_comb begin
      donor_sel_o = victim_i[VsBitA] ? CoreB : CoreA;
      case (donor_i)
         CoreA:   wr_data_o = rd_data_a_i;
         CoreB:   wr_data_o = rd_data_b_i;
         CoreC:   wr_data_o = rd_data_c_i;
         default: wr_data_o = '0;
      endcase
   end

endmodule

// File: rtl/tmr_resync_ctrl.sv
// TMR recovery engine: confirms a single outvoted core, copies the register file from a donor,
// reloads the voted PC and releases the cores. Optional TMR_RESYNC_LOG_EN adds diagnostic ports.
module tmr_resync_ctrl
   import tmr_pkg::*;
#(
   parameter int unsigned XLEN           = 32,
   parameter int unsigned NUM_REGS       = 32,
   parameter int unsigned CONFIRM_CYCLES = 2,
   parameter int unsigned CNT_W          = 8
) (
   input  logic             clk,
   input  logic             rst_in,
   input  logic [2:0]       voter_state,
   input  logic [XLEN-1:0]  pc_voted,
   output logic [4:0]       rf_rd_addr,
   input  logic [XLEN-1:0]  rf_rd_data_a,
   input  logic [XLEN-1:0]  rf_rd_data_b,
   input  logic [XLEN-1:0]  rf_rd_data_c,
   output logic [2:0]       rf_wr_en,
   output logic [4:0]       rf_wr_addr,
   output logic [XLEN-1:0]  rf_wr_data,
   output logic [2:0]       pc_load,
   output logic [XLEN-1:0]  pc_load_val,
   output logic             core_hold,
   output logic             resync_busy,
   output logic             resync_done,
   output logic             fatal_err,
   output logic [CNT_W-1:0] fault_count
`ifdef TMR_RESYNC_LOG_EN
   ,
   output logic [1:0]       last_victim,
   output logic [2:0]       fatal_state
`endif
);

   localparam int unsigned CfW     = $clog2(CONFIRM_CYCLES + 1);
   localparam logic [4:0]  LastIdx = 5'(NUM_REGS - 1);

   tmr_state_e       state_q, state_d;
   logic [CfW-1:0]   cnt_q, cnt_d;
   logic [2:0]       victim_q, victim_d;
   logic [1:0]       donor_q, donor_d;
   logic [XLEN-1:0]  pc_q, pc_d;
   logic [4:0]       idx_q, idx_d;
   logic [CNT_W-1:0] fcnt_q, fcnt_d;
   logic [1:0]       donor_sel;
   logic [XLEN-1:0]  mux_data;
   logic             multi;
`ifdef TMR_RESYNC_LOG_EN
   logic [1:0]       last_victim_q, last_victim_d;
   logic [2:0]       fatal_state_q, fatal_state_d;
`endif

   tmr_resync_mux #(
      .XLEN(XLEN)
   ) u_mux (
      .victim_i   (victim_q),
      .donor_i    (donor_q),
      .rd_data_a_i(rf_rd_data_a),
      .rd_data_b_i(rf_rd_data_b),
      .rd_data_c_i(rf_rd_data_c),
      .donor_sel_o(donor_sel),
      .wr_data_o  (mux_data)
   );

   assign multi = (voter_state != 3'b000) && !is_onehot3(voter_state);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      victim_d = victim_q;
      donor_d  = donor_q;
      pc_d     = pc_q;
      idx_d    = idx_q;
      fcnt_d   = fcnt_q;
`ifdef TMR_RESYNC_LOG_EN
      last_victim_d = last_victim_q;
      fatal_state_d = fatal_state_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (multi) begin
               state_d = StFatal;
            end else if (voter_state != 3'b000) begin
               victim_d = voter_state;
               cnt_d    = CfW'(1);
               state_d  = (CONFIRM_CYCLES == 1) ? StHold : StConfirm;
            end
         end
         StConfirm: begin
            if (multi) begin
               state_d = StFatal;
            end else if (voter_state == 3'b000) begin
               cnt_d   = '0;
               state_d = StIdle;
            end else if (voter_state == victim_q) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q + 1'b1 == CfW'(CONFIRM_CYCLES)) state_d = StHold;
            end else begin
               victim_d = voter_state;
               cnt_d    = CfW'(1);
            end
         end
         StHold: begin
            donor_d = donor_sel;
            pc_d    = pc_voted;
            idx_d   = 5'd1;
            cnt_d   = '0;
            state_d = StCopy;
         end
         StCopy: begin
            // voter_state deliberately ignored while the victim is being rewritten
            if (idx_q == LastIdx) state_d = StPcload;
            else                  idx_d   = idx_q + 5'd1;
         end
         StPcload: state_d = StRelease;
         StRelease: begin
            if (fcnt_q != '1) fcnt_d = fcnt_q + 1'b1;
`ifdef TMR_RESYNC_LOG_EN
            last_victim_d = onehot_to_code(victim_q);
`endif
            state_d = StIdle;
         end
         StFatal: state_d = StFatal;
         default: state_d = StIdle;
      endcase
`ifdef TMR_RESYNC_LOG_EN
      if (state_d == StFatal && state_q != StFatal) fatal_state_d = voter_state;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst_in) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         victim_q <= '0;
         donor_q  <= '0;
         pc_q     <= '0;
         idx_q    <= '0;
         fcnt_q   <= '0;
`ifdef TMR_RESYNC_LOG_EN
         last_victim_q <= '0;
         fatal_state_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         victim_q <= victim_d;
         donor_q  <= donor_d;
         pc_q     <= pc_d;
         idx_q    <= idx_d;
         fcnt_q   <= fcnt_d;
`ifdef TMR_RESYNC_LOG_EN
         last_victim_q <= last_victim_d;
         fatal_state_q <= fatal_state_d;
`endif
      end
   end

   always_comb begin
      core_hold   = 1'b0;
      resync_busy = 1'b0;
      resync_done = 1'b0;
      fatal_err   = 1'b0;
      rf_wr_en    = 3'b000;
      rf_wr_addr  = 5'd0;
      rf_rd_addr  = 5'd0;
      rf_wr_data  = '0;
      pc_load     = 3'b000;
      unique case (state_q)
         StHold: begin
            core_hold   = 1'b1;
            resync_busy = 1'b1;
         end
         StCopy: begin
            core_hold   = 1'b1;
            resync_busy = 1'b1;
            rf_wr_en    = victim_q;
            rf_wr_addr  = idx_q;
            rf_rd_addr  = idx_q;
            rf_wr_data  = mux_data;
         end
         StPcload: begin
            core_hold   = 1'b1;
            resync_busy = 1'b1;
            pc_load     = victim_q;
         end
         StRelease: begin
            core_hold   = 1'b1;
            resync_busy = 1'b1;
            resync_done = 1'b1;
         end
         StFatal: begin
            core_hold = 1'b1;
            fatal_err = 1'b1;
         end
         default: ;
      endcase
   end

   assign pc_load_val = pc_q;
   assign fault_count = fcnt_q;
`ifdef TMR_RESYNC_LOG_EN
   assign last_victim = last_victim_q;
   assign fatal_state = fatal_state_q;
`endif

endmodule

// File: tb/tb_tmr_resync_ctrl.sv
// Directed bench for tmr_resync_ctrl: expected writes/PC loads queued at stimulus, checked by a monitor.
module tb_tmr_resync_ctrl;

   localparam int unsigned XLEN           = 32;
   localparam int unsigned NUM_REGS       = 32;
   localparam int unsigned CONFIRM_CYCLES = 2;
   localparam int unsigned CNT_W          = 8;

   typedef struct packed {
      logic [2:0]      en;
      logic [4:0]      addr;
      logic [XLEN-1:0] data;
   } wr_t;

   typedef struct packed {
      logic [2:0]      sel;
      logic [XLEN-1:0] val;
   } pc_t;

   logic             clk = 1'b0;
   logic             rst_in;
   logic [2:0]       voter_state;
   logic [XLEN-1:0]  pc_voted;
   logic [4:0]       rf_rd_addr;
   logic [XLEN-1:0]  rf_rd_data_a, rf_rd_data_b, rf_rd_data_c;
   logic [2:0]       rf_wr_en;
   logic [4:0]       rf_wr_addr;
   logic [XLEN-1:0]  rf_wr_data;
   logic [2:0]       pc_load;
   logic [XLEN-1:0]  pc_load_val;
   logic             core_hold, resync_busy, resync_done, fatal_err;
   logic [CNT_W-1:0] fault_count;
`ifdef TMR_RESYNC_LOG_EN
   logic [1:0]       last_victim;
   logic [2:0]       fatal_state;
`endif

   logic [XLEN-1:0] rf_a [NUM_REGS];
   logic [XLEN-1:0] rf_b [NUM_REGS];
   logic [XLEN-1:0] rf_c [NUM_REGS];

   wr_t wr_q[$];
   pc_t pcl_q[$];
   int  n_pass  = 0;
   int  n_total = 0;
   int  done_cnt = 0;
   bit  mon_en = 1'b0;
   int  lat;

   always #5 clk = ~clk;

   assign rf_rd_data_a = rf_a[rf_rd_addr];
   assign rf_rd_data_b = rf_b[rf_rd_addr];
   assign rf_rd_data_c = rf_c[rf_rd_addr];

   tmr_resync_ctrl #(
      .XLEN          (XLEN),
      .NUM_REGS      (NUM_REGS),
      .CONFIRM_CYCLES(CONFIRM_CYCLES),
      .CNT_W         (CNT_W)
   ) dut (
      .clk         (clk),
      .rst_in      (rst_in),
      .voter_state (voter_state),
      .pc_voted    (pc_voted),
      .rf_rd_addr  (rf_rd_addr),
      .rf_rd_data_a(rf_rd_data_a),
      .rf_rd_data_b(rf_rd_data_b),
      .rf_rd_data_c(rf_rd_data_c),
      .rf_wr_en    (rf_wr_en),
      .rf_wr_addr  (rf_wr_addr),
      .rf_wr_data  (rf_wr_data),
      .pc_load     (pc_load),
      .pc_load_val (pc_load_val),
      .core_hold   (core_hold),
      .resync_busy (resync_busy),
      .resync_done (resync_done),
      .fatal_err   (fatal_err),
      .fault_count (fault_count)
`ifdef TMR_RESYNC_LOG_EN
      ,
      .last_victim (last_victim),
      .fatal_state (fatal_state)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Donor is B when A is the victim, otherwise A.
   task automatic push_recovery(input logic [2:0] victim, input logic [XLEN-1:0] pc);
      wr_t w;
      pc_t p;
      for (int i = 1; i < NUM_REGS; i++) begin
         w.en   = victim;
         w.addr = 5'(i);
         w.data = (victim == 3'b001) ? rf_b[i] : rf_a[i];
         wr_q.push_back(w);
      end
      p.sel = victim;
      p.val = pc;
      pcl_q.push_back(p);
   endtask

   // Waits for hold to fall; counts negedges from the first mismatch drive (start = already elapsed).
   // Also pokes voter_state during COPY, which the DUT must ignore.
   task automatic wait_release(input int start, output int cyc);
      bit seen_hi;
      seen_hi = 1'b0;
      cyc = start;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         cyc++;
         if (cyc == 10) voter_state = 3'b101;
         if (cyc == 20) voter_state = 3'b000;
         if (core_hold) seen_hi = 1'b1;
         else if (seen_hi) break;
      end
      voter_state = 3'b000;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (rf_wr_en !== 3'b000) begin
            if (wr_q.size() == 0) begin
               check("unexpected_write", {56'd0, rf_wr_en, rf_wr_addr}, 64'd0);
            end else begin
               wr_t e;
               e = wr_q.pop_front();
               check("rf_write", {24'd0, rf_wr_en, rf_wr_addr, rf_wr_data},
                     {24'd0, e.en, e.addr, e.data});
               check("rf_rd_addr", {59'd0, rf_rd_addr}, {59'd0, e.addr});
            end
         end
         if (pc_load !== 3'b000) begin
            if (pcl_q.size() == 0) begin
               check("unexpected_pc_load", {61'd0, pc_load}, 64'd0);
            end else begin
               pc_t p;
               p = pcl_q.pop_front();
               check("pc_load", {29'd0, pc_load, pc_load_val}, {29'd0, p.sel, p.val});
            end
         end
         if (resync_done === 1'b1) done_cnt++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < NUM_REGS; i++) begin
         rf_a[i] = 32'hA000_0000 | 32'(i) | (32'($urandom_range(0, 255)) << 8);
         rf_b[i] = 32'hB000_0000 | 32'(i) | (32'($urandom_range(0, 255)) << 8);
         rf_c[i] = 32'hC000_0000 | 32'(i) | (32'($urandom_range(0, 255)) << 8);
      end
      rst_in      = 1'b1;
      voter_state = 3'b000;
      pc_voted    = '0;
      repeat (2) @(negedge clk);
      check("rst_core_hold", {63'd0, core_hold}, 64'd0);
      check("rst_busy_done_fatal", {61'd0, resync_busy, resync_done, fatal_err}, 64'd0);
      check("rst_wr", {56'd0, rf_wr_en, rf_wr_addr}, 64'd0);
      check("rst_pc", {29'd0, pc_load, pc_load_val}, 64'd0);
      check("rst_fault_count", {56'd0, fault_count}, 64'd0);
      rst_in = 1'b0;
      mon_en = 1'b1;

      // Single-cycle glitch: no recovery.
      voter_state = 3'b001;
      @(negedge clk);
      voter_state = 3'b000;
      repeat (4) @(negedge clk);
      check("glitch_no_hold", {63'd0, core_hold}, 64'd0);
      check("glitch_fault_count", {56'd0, fault_count}, 64'd0);

      // Victim B, donor A.
      push_recovery(3'b010, 32'h0000_0040);
      voter_state = 3'b010;
      pc_voted    = 32'h0000_0040;
      @(negedge clk);
      check("b_hold_after_1", {63'd0, core_hold}, 64'd0);
      @(negedge clk);
      check("b_hold_after_2", {62'd0, core_hold, resync_busy}, 64'd3);
      wait_release(2, lat);
      check("b_latency", 64'(lat), 64'd36);
      check("b_writes_drained", 64'(wr_q.size()), 64'd0);
      check("b_pcload_drained", 64'(pcl_q.size()), 64'd0);
      check("b_done_pulses", 64'(done_cnt), 64'd1);
      check("b_fault_count", {56'd0, fault_count}, 64'd1);
`ifdef TMR_RESYNC_LOG_EN
      check("b_last_victim", {62'd0, last_victim}, 64'd2);
`endif

      // Victim A, donor B.
      push_recovery(3'b001, 32'h0000_1234);
      voter_state = 3'b001;
      pc_voted    = 32'h0000_1234;
      wait_release(0, lat);
      check("a_latency", 64'(lat), 64'd36);
      check("a_writes_drained", 64'(wr_q.size()), 64'd0);
      check("a_pcload_drained", 64'(pcl_q.size()), 64'd0);
      check("a_done_pulses", 64'(done_cnt), 64'd2);
      check("a_fault_count", {56'd0, fault_count}, 64'd2);
      repeat (3) @(negedge clk);
      check("a_idle_after", {63'd0, core_hold}, 64'd0);

      // Reset in the middle of COPY.
      push_recovery(3'b100, 32'h0000_0080);
      voter_state = 3'b100;
      pc_voted    = 32'h0000_0080;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (rf_wr_en !== 3'b000 && rf_wr_addr == 5'd10) break;
      end
      check("abort_reached_idx10", {59'd0, rf_wr_addr}, 64'd10);
      rst_in = 1'b1;
      @(negedge clk);
      rst_in = 1'b0;
      voter_state = 3'b000;
      check("abort_hold", {62'd0, core_hold, resync_busy}, 64'd0);
      check("abort_wr", {56'd0, rf_wr_en, rf_wr_addr}, 64'd0);
      check("abort_wr_data", {32'd0, rf_wr_data}, 64'd0);
      check("abort_pc", {29'd0, pc_load, pc_load_val}, 64'd0);
      check("abort_fault_count", {56'd0, fault_count}, 64'd0);
      wr_q.delete();
      pcl_q.delete();
      repeat (3) @(negedge clk);
      check("abort_stays_idle", {63'd0, core_hold}, 64'd0);

      // A then C twice: confirm restarts, victim C, donor A.
      push_recovery(3'b100, 32'h0000_0100);
      pc_voted    = 32'h0000_0100;
      voter_state = 3'b001;
      @(negedge clk);
      voter_state = 3'b100;
      @(negedge clk);
      check("c_no_hold_yet", {63'd0, core_hold}, 64'd0);
      @(negedge clk);
      check("c_hold", {63'd0, core_hold}, 64'd1);
      wait_release(3, lat);
      check("c_latency", 64'(lat), 64'd37);
      check("c_writes_drained", 64'(wr_q.size()), 64'd0);
      check("c_pcload_drained", 64'(pcl_q.size()), 64'd0);
      check("c_fault_count", {56'd0, fault_count}, 64'd1);
`ifdef TMR_RESYNC_LOG_EN
      check("c_last_victim", {62'd0, last_victim}, 64'd3);
`endif

      // Two cores outvoted: fatal until reset.
      voter_state = 3'b011;
      @(negedge clk);
      voter_state = 3'b000;
      check("fatal_entry", {62'd0, fatal_err, core_hold}, 64'd3);
      repeat (6) @(negedge clk);
      check("fatal_sticky", {62'd0, fatal_err, core_hold}, 64'd3);
      check("fatal_no_busy", {63'd0, resync_busy}, 64'd0);
`ifdef TMR_RESYNC_LOG_EN
      check("fatal_state", {61'd0, fatal_state}, 64'd3);
`endif
      rst_in = 1'b1;
      @(negedge clk);
      rst_in = 1'b0;
      check("fatal_cleared", {62'd0, fatal_err, core_hold}, 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/tmr_resync_ctrl.md
Name: tmr_resync_ctrl

Overview:
Recovery engine at the far end of the TMR voting path: consumes the voter's per-core mismatch flags and repairs the outvoted core.
- Holds all three cores.
- Copies the architectural register file from a healthy donor core into the faulty victim core, one register per cycle.
- Reloads the victim PC with the voted PC, then releases the cores.
- Sits beside the voter and lockstep logic in the TMR top; drives the cores' register-file repair ports and the core hold.

Parameters:
XLEN, 32, data/PC width
NUM_REGS, 32, architectural registers; x0 never copied
CONFIRM_CYCLES, 2, consecutive identical single-core mismatch cycles required before recovery starts (>=1)
CNT_W, 8, width of fault_count

Ports:
clk  in  1  clock
rst_in  in  1  synchronous reset, active-high
voter_state  in  3  mismatch flags; bit0=core A, bit1=B, bit2=C outvoted; 000=all agree
pc_voted  in  XLEN  voted PC from voter
rf_rd_addr  out  5  donor register-file read address (async read)
rf_rd_data_a/b/c  in  XLEN  each core's register-file repair read port
rf_wr_en  out  3  one-hot victim write enable (bit0=A)
rf_wr_addr  out  5  victim write address
rf_wr_data  out  XLEN  victim write data
pc_load  out  3  one-hot one-cycle PC load strobe to victim
pc_load_val  out  XLEN  PC value to load
core_hold  out  1  stall all three cores
resync_busy  out  1  high from HOLD through RELEASE
resync_done  out  1  one-cycle pulse on RELEASE
fatal_err  out  1  sticky uncorrectable fault
fault_count  out  CNT_W  completed recoveries, saturating

Behaviour:
- Reset (synchronous, rst_in=1 at a clk edge): state=IDLE. Every output is 0. The confirm counter and the latched victim, donor and PC are cleared. A reset mid-recovery aborts immediately; hold drops on the next cycle.
- IDLE
  - voter_state one-hot -> CONFIRM, confirm count=1.
  - Two or more bits set -> FATAL.
- CONFIRM
  - Same one-hot value again: increment count; at CONFIRM_CYCLES -> HOLD.
  - Value changes to another one-hot: restart count at 1.
  - 000: back to IDLE (transient glitch, no action).
  - Two or more bits set -> FATAL.
  - With CONFIRM_CYCLES=1, go straight IDLE->HOLD on the first one-hot cycle.
- HOLD (1 cycle)
  - core_hold=1.
  - Latch victim = flagged core.
  - Latch donor = lowest-indexed non-victim core (A victim -> B donor; otherwise A).
  - Latch pc_voted into pc_load_val.
  - -> COPY, reg index=1.
- COPY
  - rf_rd_addr = rf_wr_addr = index.
  - rf_wr_data = donor's rf_rd_data, combinational same cycle.
  - rf_wr_en = victim one-hot.
  - One register per cycle, index 1..NUM_REGS-1 (31 cycles).
  - At the last index -> PCLOAD.
  - voter_state is ignored during COPY.
- PCLOAD (1 cycle): pc_load = victim one-hot, pc_load_val = latched PC. -> RELEASE.
- RELEASE (1 cycle): resync_done=1, fault_count += 1 (saturates at 2^CNT_W-1), core_hold=1 this cycle. -> IDLE; core_hold=0 from the next cycle.
- FATAL: core_hold=1 and fatal_err=1 permanently; leave only on reset.
- core_hold and resync_busy are 1 in HOLD, COPY, PCLOAD and RELEASE.
- Latency from first mismatch cycle to hold release: CONFIRM_CYCLES + NUM_REGS + 2 cycles.
- Outside COPY: rf_wr_en=0, rf_rd_addr=0.
- Outside PCLOAD: pc_load=0.

Optional Feature:
TMR_RESYNC_LOG_EN
- Defined: add output last_victim (2 bits, 1=A, 2=B, 3=C, 0=none), updated in RELEASE.
- Defined: add output fatal_state (3 bits), capturing voter_state on FATAL entry.
- Not defined: neither port exists; all other behaviour identical.

Decomposition:
- Shared package tmr_pkg holds:
  - the state enum (IDLE, CONFIRM, HOLD, COPY, PCLOAD, RELEASE, FATAL)
  - the voter_state bit positions
  - core index constants
  - a one-hot-check function
- The voter will reuse this package.
- Natural sub-module: tmr_resync_mux, a combinational donor-select and rf_wr_data mux.

Test Plan:
- voter_state=001 for 1 cycle then 000 -> no hold, fault_count=0.
- voter_state=010 held with pc_voted=0x0000_0040:
  - core_hold rises after 2 cycles.
  - Donor A.
  - rf_wr_en=010 for addr 1..31 with A's values.
  - pc_load=010 with 0x40.
  - resync_done pulse; fault_count=1.
- voter_state=001:
  - Donor B.
  - x0 never written.
  - Exactly 31 write cycles.
  - Hold drops 36 cycles after first mismatch (CONFIRM_CYCLES=2).
- voter_state=011 -> FATAL: fatal_err=1, core_hold=1 indefinitely; rst_in=1 clears both next cycle.
- rst_in=1 at COPY index 10 -> all outputs 0 next cycle, state IDLE, fault_count=0.
- voter_state 001 then 100 then 100 -> count restarts; victim C.
